// File: rtl/vec_chk_pkg.sv
// Shared definitions for the locked vector checker: one-hot state
// encoding, state bit positions, key-bit indices and the FAIL_NONE helper.
package vec_chk_pkg;

    localparam int I_IDLE  = 0;
    localparam int I_FETCH = 1;
    localparam int I_LOAD  = 2;
    localparam int I_CALL  = 3;
    localparam int I_WAIT  = 4;
    localparam int I_CHECK = 5;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_FETCH = 6'b000010,
        S_LOAD  = 6'b000100,
        S_CALL  = 6'b001000,
        S_WAIT  = 6'b010000,
        S_CHECK = 6'b100000
    } state_t;

    // A set bit of (working_key ^ CORRECT_KEY) corrupts one branch.
    localparam int K_NO_FETCH  = 0;
    localparam int K_END_CHECK = 1;
    localparam int K_SKIP_CALL = 2;
    localparam int K_NO_WAIT   = 3;

    // All-ones index of width w, meaning "no failure recorded".
    function automatic logic [31:0] fail_none(input int unsigned w);
        return (32'h1 << w) - 32'h1;
    endfunction

endpackage

// File: rtl/vec_chk_timeout.sv
// Loadable down-counter bounding the WAIT state.
// Ports: ap_clk/ap_rst clock and sync reset, load (restart), en (count),
// expired (high on the TIMEOUT-th enabled cycle after a load).
module vec_chk_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [W-1:0] LOAD_V = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Loaded with TIMEOUT-1 so that zero lines up with the last
    // permitted WAIT cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_V;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/locked_vector_checker.sv
// Logic-locked vector harness: walks NUM_VEC ROM triples, drives an
// external operator via op_start/op_ready/op_done, compares results to
// golden and reports mismatch count, first failing index, timeout and
// skip counts. Ports: ap_* block control, working_key lock input,
// vec_* ROM interface, op_* operator handshake and operands.
module locked_vector_checker
    import vec_chk_pkg::*;
#(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned NUM_VEC        = 22,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT        = 255,
    parameter bit          SKIP_SAME_SIGN = 1'b1,
    parameter logic [3:0]  CORRECT_KEY    = 4'b0000
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [CNT_W-1:0]  ap_return,
    output logic [ADDR_W-1:0] fail_idx,
    output logic [CNT_W-1:0]  timeout_cnt,
    output logic [CNT_W-1:0]  skip_cnt,
    input  logic [3:0]        working_key,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              vec_ce,
    input  logic [DATA_W-1:0] vec_a,
    input  logic [DATA_W-1:0] vec_b,
    input  logic [DATA_W-1:0] vec_z,
    output logic              op_start,
    input  logic              op_ready,
    input  logic              op_done,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] op_result
);

    localparam logic [ADDR_W-1:0] FAIL_NONE = ADDR_W'(fail_none(ADDR_W));
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(NUM_VEC);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] gold_q;
    logic [DATA_W-1:0] res_q;
    logic              chk_en;
    logic              op_start_q;
    logic              op_start_nxt;
    logic              expired;
    logic              last;
    logic              skip;
    logic [3:0]        kx;

    assign kx   = working_key ^ CORRECT_KEY;
    assign last = (idx == LAST);
    assign skip = SKIP_SAME_SIGN && (vec_a[DATA_W-1] == vec_b[DATA_W-1]);

    assign vec_addr = idx;
    assign vec_ce   = state[I_FETCH];
    assign ap_done  = state[I_FETCH] && last;
    assign ap_ready = ap_done;
    assign ap_idle  = state[I_IDLE] && !ap_start;
    assign op_start = op_start_q;

    vec_chk_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .load   (state[I_CALL]),
        .en     (state[I_WAIT]),
        .expired(expired)
    );

    always_comb begin
        nxt = state;
        unique case (1'b1)
            state[I_IDLE]:
                if (ap_start) nxt = kx[K_NO_FETCH] ? S_LOAD : S_FETCH;
            state[I_FETCH]:
                if (last) nxt = kx[K_END_CHECK] ? S_CHECK : S_IDLE;
                else      nxt = S_LOAD;
            state[I_LOAD]:
                if (skip) nxt = kx[K_SKIP_CALL] ? S_CALL : S_CHECK;
                else      nxt = S_CALL;
            state[I_CALL]:
                nxt = kx[K_NO_WAIT] ? S_CHECK : S_WAIT;
            state[I_WAIT]:
                if (op_done || expired) nxt = S_CHECK;
            state[I_CHECK]:
                nxt = S_FETCH;
            default:
                nxt = S_IDLE;
        endcase
    end

    // op_start rises entering WAIT and holds until the cycle op_ready
    // is seen; it never survives leaving WAIT.
    always_comb begin
        op_start_nxt = 1'b0;
        if (state[I_CALL] && (nxt == S_WAIT)) begin
            op_start_nxt = 1'b1;
        end else if (state[I_WAIT] && (nxt == S_WAIT)) begin
            op_start_nxt = op_start_q && !op_ready;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            gold_q      <= '0;
            res_q       <= '0;
            chk_en      <= 1'b0;
            op_start_q  <= 1'b0;
            ap_return   <= '0;
            fail_idx    <= FAIL_NONE;
            timeout_cnt <= '0;
            skip_cnt    <= '0;
        end else begin
            state      <= nxt;
            op_start_q <= op_start_nxt;
            unique case (1'b1)
                state[I_IDLE]: begin
                    if (ap_start) begin
                        idx         <= '0;
                        ap_return   <= '0;
                        timeout_cnt <= '0;
                        skip_cnt    <= '0;
                        fail_idx    <= FAIL_NONE;
                    end
                end
                state[I_LOAD]: begin
                    op_a   <= vec_a;
                    op_b   <= vec_b;
                    gold_q <= vec_z;
                    chk_en <= !skip;
                    if (skip) skip_cnt <= sat_inc(skip_cnt);
                end
                state[I_WAIT]: begin
                    if (op_done) begin
                        res_q <= op_result;
                    end else if (expired) begin
                        // Abandoned vector counts as a mismatch.
                        chk_en      <= 1'b0;
                        timeout_cnt <= sat_inc(timeout_cnt);
                        ap_return   <= sat_inc(ap_return);
                        if (fail_idx == FAIL_NONE) fail_idx <= idx;
                    end
                end
                state[I_CHECK]: begin
                    if (chk_en && (res_q != gold_q)) begin
                        ap_return <= sat_inc(ap_return);
                        if (fail_idx == FAIL_NONE) fail_idx <= idx;
                    end
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
